// File: rtl/regfile_pkg.sv
// Shared types, default constants and address-match helper for the register file slice.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_PC_IDX    = 15;
  localparam int unsigned DEF_PC_OFFSET = 8;

  typedef logic [DEF_WIDTH-1:0] word_t;

  // Callers zero-extend addresses to 32 bits so one helper serves any AW.
  function automatic logic addr_hit(input logic we, input logic [31:0] wa, input logic [31:0] a);
    return we && (wa == a);
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard: reserve sets, writeback clears, registered re-reserve conflict pulse.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS  = 16,
  parameter  int unsigned PC_IDX = DEF_PC_IDX,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [NREGS-1:0] clr,
  output logic [NREGS-1:0] busy,
  output logic             rsv_conflict
);

  logic rsv_ok;

  // The virtual PC register can never be reserved, so it never reads busy.
  assign rsv_ok = rsv_en && (32'(rsv_addr) != PC_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (rsv_ok && (32'(rsv_addr) == r))
          busy[r] <= 1'b1;
        else if (clr[r])
          busy[r] <= 1'b0;
      end
      rsv_conflict <= rsv_ok && busy[rsv_addr] && !clr[rsv_addr];
    end
  end

endmodule

// File: rtl/regfile_scoreboard_bypass.sv
// Register file with two write ports, same-cycle write bypass, virtual PC register and busy scoreboard.
module regfile_scoreboard_bypass
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned NREGS     = 16,
  parameter  int unsigned NREAD     = 2,
  parameter  int unsigned PC_IDX    = DEF_PC_IDX,
  parameter  int unsigned PC_OFFSET = DEF_PC_OFFSET,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_ready,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd1,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic [WIDTH-1:0]       pc_in,
  output logic                   pc_wr_valid,
  output logic [WIDTH-1:0]       pc_wr_data,
  output logic                   rsv_conflict
);

  logic [NREGS-1:0] wen0, wen1, wr_any, busy;
  logic [WIDTH-1:0] mem [NREGS];
  logic             pc_hit0, pc_hit1;
  logic [AW-1:0]    ra;
  logic             hit0, hit1;

  // Write-enable decode; the PC slot is excluded so it never touches the array.
  always_comb begin
    wen0 = '0;
    wen1 = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      wen0[r] = addr_hit(we0, 32'(wa0), r) && (r != PC_IDX);
      wen1[r] = addr_hit(we1, 32'(wa1), r) && (r != PC_IDX);
    end
  end

  assign wr_any  = wen0 | wen1;
  assign pc_hit0 = addr_hit(we0, 32'(wa0), PC_IDX);
  assign pc_hit1 = addr_hit(we1, 32'(wa1), PC_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (wen1[r])
          mem[r] <= wd1;
        else if (wen0[r])
          mem[r] <= wd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_wr_valid <= 1'b0;
      pc_wr_data  <= '0;
    end else begin
      pc_wr_valid <= pc_hit0 || pc_hit1;
      if (pc_hit1)
        pc_wr_data <= wd1;
      else if (pc_hit0)
        pc_wr_data <= wd0;
    end
  end

  // Read priority: PC override, then load port, then ALU port, then array.
  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    ra       = '0;
    hit0     = 1'b0;
    hit1     = 1'b0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra   = rd_addr[k*AW +: AW];
      hit0 = addr_hit(we0, 32'(wa0), 32'(ra));
      hit1 = addr_hit(we1, 32'(wa1), 32'(ra));
      if (32'(ra) == PC_IDX) begin
        rd_data[k*WIDTH +: WIDTH] = pc_in + WIDTH'(PC_OFFSET);
        rd_ready[k]               = 1'b1;
      end else begin
        if (hit1)
          rd_data[k*WIDTH +: WIDTH] = wd1;
        else if (hit0)
          rd_data[k*WIDTH +: WIDTH] = wd0;
        else
          rd_data[k*WIDTH +: WIDTH] = mem[ra];
        rd_ready[k] = !busy[ra] || hit0 || hit1;
      end
    end
  end

  regfile_busy_tracker #(
    .NREGS  (NREGS),
    .PC_IDX (PC_IDX)
  ) u_busy (
    .clk          (clk),
    .reset        (reset),
    .rsv_en       (rsv_en),
    .rsv_addr     (rsv_addr),
    .clr          (wr_any),
    .busy         (busy),
    .rsv_conflict (rsv_conflict)
  );

endmodule

// File: tb/tb_regfile_scoreboard_bypass.sv
// Bench for regfile_scoreboard_bypass: directed literal checks plus randomized traffic against an array model.
module tb_regfile_scoreboard_bypass;

  localparam int W = 32, N = 16, NR = 2, AW = 4, PCI = 15, PCO = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_ready;
  logic             we0, we1, rsv_en;
  logic [AW-1:0]    wa0, wa1, rsv_addr;
  logic [W-1:0]     wd0, wd1, pc_in;
  logic             pc_wr_valid, rsv_conflict;
  logic [W-1:0]     pc_wr_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_reg [N];
  logic         m_busy [N];
  logic         m_pcv, m_conf;
  logic [W-1:0] m_pcd;

  always #5 clk = ~clk;

  regfile_scoreboard_bypass #(
    .WIDTH(W), .NREGS(N), .NREAD(NR), .PC_IDX(PCI), .PC_OFFSET(PCO)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pc_in(pc_in),
    .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data), .rsv_conflict(rsv_conflict)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_data(input int a);
    if (a == PCI) return pc_in + PCO;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_reg[a];
  endfunction

  function automatic logic exp_ready(input int a);
    if (a == PCI) return 1'b1;
    return !m_busy[a] || (we1 && wa1 == a) || (we0 && wa0 == a);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_pcv = 1'b0; m_pcd = '0; m_conf = 1'b0;
  endtask

  task automatic model_clock();
    bit w0, w1;
    w0 = we0 && wa0 != PCI;
    w1 = we1 && wa1 != PCI;
    m_conf = rsv_en && rsv_addr != PCI && m_busy[rsv_addr] &&
             !((w0 && wa0 == rsv_addr) || (w1 && wa1 == rsv_addr));
    if (w0) begin m_reg[wa0] = wd0; m_busy[wa0] = 1'b0; end
    if (w1) begin m_reg[wa1] = wd1; m_busy[wa1] = 1'b0; end
    if (rsv_en && rsv_addr != PCI) m_busy[rsv_addr] = 1'b1;
    m_pcv = (we0 && wa0 == PCI) || (we1 && wa1 == PCI);
    if (we1 && wa1 == PCI) m_pcd = wd1;
    else if (we0 && wa0 == PCI) m_pcd = wd0;
  endtask

  task automatic compare();
    for (int k = 0; k < NR; k++) begin
      chk("rd_data", rd_data[k*W +: W], exp_data(int'(rd_addr[k*AW +: AW])));
      chk("rd_ready", W'(rd_ready[k]), W'(exp_ready(int'(rd_addr[k*AW +: AW]))));
    end
    chk("pc_wr_valid", W'(pc_wr_valid), W'(m_pcv));
    chk("pc_wr_data", pc_wr_data, m_pcd);
    chk("rsv_conflict", W'(rsv_conflict), W'(m_conf));
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    if (reset) model_reset(); else model_clock();
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; rsv_addr = '0;
  endtask

  task automatic set_port(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  initial begin
    idle();
    rd_addr = '0;
    pc_in   = 32'h100;
    reset   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset contents and PC read.
    for (int a = 0; a < N; a++) begin
      set_port(0, AW'(a));
      set_port(1, AW'(a));
      #1;
      chk("reset_data0", rd_data[W-1:0], (a == PCI) ? 32'h108 : 32'h0);
      chk("reset_data1", rd_data[2*W-1:W], (a == PCI) ? 32'h108 : 32'h0);
      chk("reset_ready", W'(rd_ready), W'(2'b11));
    end
    chk("reset_pcv", W'(pc_wr_valid), '0);
    chk("reset_conf", W'(rsv_conflict), '0);
    step();

    // ALU write bypass, then stored.
    we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; set_port(0, 3); set_port(1, 4);
    #1 chk("bypass0", rd_data[W-1:0], 32'hDEADBEEF);
    step();
    idle();
    #1 chk("stored0", rd_data[W-1:0], 32'hDEADBEEF);
    step();

    // Both ports to same register: load port wins.
    we0 = 1; wa0 = 5; wd0 = 32'h11; we1 = 1; wa1 = 5; wd1 = 32'h22; set_port(0, 5);
    #1 chk("dual_bypass", rd_data[W-1:0], 32'h22);
    step();
    idle();
    #1 chk("dual_stored", rd_data[W-1:0], 32'h22);
    step();

    // Reserve, then writeback clears.
    rsv_en = 1; rsv_addr = 7; set_port(0, 7);
    #1 chk("rsv_same_cycle_ready", W'(rd_ready[0]), 32'h1);
    step();
    idle();
    #1 chk("rsv_busy", W'(rd_ready[0]), 32'h0);
    step();
    we1 = 1; wa1 = 7; wd1 = 32'h55;
    #1 chk("wb_ready", W'(rd_ready[0]), 32'h1);
    chk("wb_data", rd_data[W-1:0], 32'h55);
    step();
    idle();
    #1 chk("wb_cleared", W'(rd_ready[0]), 32'h1);
    step();

    // Re-reserve conflict pulse, then reserve+write same cycle.
    rsv_en = 1; rsv_addr = 7;
    step();
    #0 chk("no_conf_first", W'(rsv_conflict), 32'h0);
    step();
    chk("conf_pulse", W'(rsv_conflict), 32'h1);
    idle();
    step();
    chk("conf_one_cycle", W'(rsv_conflict), 32'h0);
    rsv_en = 1; rsv_addr = 7; we0 = 1; wa0 = 7; wd0 = 32'h77;
    step();
    idle();
    #1 chk("rsvwr_busy", W'(rd_ready[0]), 32'h0);
    chk("rsvwr_data", rd_data[W-1:0], 32'h77);
    chk("rsvwr_noconf", W'(rsv_conflict), 32'h0);
    step();

    // PC write redirect, then reset mid-pulse.
    we0 = 1; wa0 = 4'(PCI); wd0 = 32'h4000; set_port(1, 4'(PCI)); pc_in = 32'h200;
    #1 chk("pc_read", rd_data[2*W-1:W], 32'h208);
    step();
    idle();
    #1 chk("pc_wr_valid", W'(pc_wr_valid), 32'h1);
    chk("pc_wr_data", pc_wr_data, 32'h4000);
    compare();
    reset = 1'b1;
    #1 chk("pc_reset_async", W'(pc_wr_valid), 32'h0);
    model_reset();
    step();
    reset = 1'b0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      we0      = ($urandom_range(0, 2) == 0);
      we1      = ($urandom_range(0, 3) == 0);
      wa0      = AW'($urandom_range(0, N - 1));
      wa1      = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, N - 1));
      wd0      = $urandom;
      wd1      = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, N - 1));
      rd_addr  = NR*AW'($urandom);
      pc_in    = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
